// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and FIFO entry type for the fetch stage
package if_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // addi x0,x0,0
  localparam logic [DATA_WIDTH-1:0] NOP              = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] ZERO             = '0;
  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_WIDTH-1:0] INST_STEP        = 32'd4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction bus request/grant/response bundle
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous {addr,inst} FIFO with push/pop/clear and occupancy
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy next state; clear discards everything, including a same-cycle push
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live
  always_ff @(posedge clk_in) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, bus credit, redirect drop, if_id register
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = NOP
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  if_fetch_if.master            ibus,
  input  logic                  stall_in,
  input  logic                  jump_flag_in,
  input  logic [ADDR_WIDTH-1:0] jump_addr_in,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_addr_out,
  output logic                  inst_valid_out
);

  localparam int             CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]    CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;      // address of the next response that will be kept
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic                  inst_valid_q, inst_valid_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_empty, fifo_full;
  logic          fire, rsp_ok, push, pop;
  fetch_entry_t  push_entry, head_entry;

  // Requests are capped so every outstanding response is guaranteed a FIFO slot
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign ibus.req    = !reset_in && !jump_flag_in && (credit_used < CREDIT_MAX);
  assign ibus.addr   = pc_q;

  assign fire   = ibus.req && ibus.gnt;
  assign rsp_ok = ibus.rvalid && (inflight_q != '0);
  assign pop    = !jump_flag_in && !stall_in && !fifo_empty;
  assign push   = rsp_ok && (drop_q == '0) && !jump_flag_in && (!fifo_full || pop);

  assign push_entry = '{addr: tail_q, inst: ibus.rdata};

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .push_i   (push),
    .pop_i    (pop),
    .clear_i  (jump_flag_in),
    .wdata_i  (push_entry),
    .rdata_o  (head_entry),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

  // Next state: PC/credit/drop bookkeeping, then output register in flush > stall > pop > idle order
  always_comb begin
    pc_d         = pc_q;
    tail_d       = tail_q;
    inflight_d   = inflight_q + CW'(fire) - CW'(rsp_ok);
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;

    if (fire) pc_d = pc_q + INST_STEP;
    if (push) tail_d = tail_q + INST_STEP;
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);

    if (jump_flag_in) begin
      // Everything still outstanding after this cycle belongs to the old path
      pc_d         = jump_addr_in;
      tail_d       = jump_addr_in;
      drop_d       = inflight_d;
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end else if (stall_in) begin
      inst_d       = inst_q;
    end else if (!fifo_empty) begin
      inst_d       = head_entry.inst;
      inst_addr_d  = head_entry.addr;
      inst_valid_d = 1'b1;
    end else begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pc_q         <= RESET_PC;
      tail_q       <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= ZERO;
      inst_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      tail_q       <= tail_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_out       = inst_q;
  assign inst_addr_out  = inst_addr_q;
  assign inst_valid_out = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with queue-based reference model
module tb_if_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        stall_in;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_valid_out;

  if_fetch_if ibus ();

  if_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP_V)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .ibus           (ibus),
    .stall_in       (stall_in),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .inst_out       (inst_out),
    .inst_addr_out  (inst_addr_out),
    .inst_valid_out (inst_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus slave: grants per gnt_en, answers in order one cycle later, mem[i]=i
  bit          gnt_en = 0;
  bit          rsp_en = 0;
  logic [31:0] mem_pend[$];

  always @(posedge clk_in) begin
    logic [31:0] a;
    #2;
    ibus.gnt = gnt_en;
    if (rsp_en && mem_pend.size() > 0) begin
      a           = mem_pend.pop_front();
      ibus.rvalid = 1'b1;
      ibus.rdata  = a >> 2;
    end else begin
      ibus.rvalid = 1'b0;
      ibus.rdata  = '0;
    end
  end

  // ---------------- reference model: counts and queues of addresses/words
  logic [31:0] m_pc     = 32'h0;
  int          m_inflight = 0;
  int          m_drop   = 0;
  logic [31:0] m_inaddr[$];
  logic [63:0] m_fifo[$];
  logic [31:0] m_inst   = NOP_V;
  logic [31:0] m_iaddr  = 32'h0;
  logic        m_valid  = 1'b0;

  task automatic model_reset();
    m_pc       = 32'h0;
    m_inflight = 0;
    m_drop     = 0;
    m_inaddr.delete();
    m_fifo.delete();
    m_inst     = NOP_V;
    m_iaddr    = 32'h0;
    m_valid    = 1'b0;
  endtask

  function automatic bit model_req();
    return !reset_in && !jump_flag_in && (m_inflight + m_fifo.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit          fire, rv_ok, do_pop;
    logic [63:0] head;
    logic [31:0] a;
    head   = '0;
    fire   = model_req() && ibus.gnt;
    rv_ok  = ibus.rvalid && (m_inflight > 0);
    do_pop = !jump_flag_in && !stall_in && (m_fifo.size() > 0);
    if (do_pop) head = m_fifo.pop_front();
    if (rv_ok) begin
      a = m_inaddr.pop_front();
      m_inflight--;
      if (m_drop > 0) m_drop--;
      else if (!jump_flag_in) m_fifo.push_back({a, ibus.rdata});
    end
    if (fire) begin
      m_inaddr.push_back(m_pc);
      m_pc = m_pc + 32'd4;
      m_inflight++;
    end
    if (jump_flag_in) begin
      m_pc = jump_addr_in;
      m_fifo.delete();
      m_drop  = m_inflight;
      m_inst  = NOP_V;
      m_valid = 1'b0;
    end else if (stall_in) begin
      m_valid = m_valid;
    end else if (do_pop) begin
      m_inst  = head[31:0];
      m_iaddr = head[63:32];
      m_valid = 1'b1;
    end else begin
      m_inst  = NOP_V;
      m_valid = 1'b0;
    end
  endtask

  // Compare every cycle at the falling edge, then advance the model with this cycle's inputs
  always @(negedge clk_in) begin
    if (reset_in) model_reset();
    chk("ibus_req",   {31'b0, ibus.req},       {31'b0, model_req()});
    chk("ibus_addr",  ibus.addr,               m_pc);
    chk("inst_out",   inst_out,                m_inst);
    chk("inst_addr",  inst_addr_out,           m_iaddr);
    chk("inst_valid", {31'b0, inst_valid_out}, {31'b0, m_valid});
    if (!reset_in) begin
      if (ibus.req && ibus.gnt) mem_pend.push_back(ibus.addr);
      model_step();
    end
  end

  // ---------------- directed stimulus
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      to_neg();
      if (inst_valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no valid instruction within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in     = 1'b1;
    stall_in     = 1'b0;
    jump_flag_in = 1'b0;
    jump_addr_in = 32'h0;

    // reset values
    to_neg();
    chk("rst_req",   {31'b0, ibus.req},       32'h0);
    chk("rst_inst",  inst_out,                NOP_V);
    chk("rst_iaddr", inst_addr_out,           32'h0);
    chk("rst_valid", {31'b0, inst_valid_out}, 32'h0);

    // release; cycle 0 starts here with a zero-wait bus
    step();
    reset_in = 1'b0;
    gnt_en   = 1'b1;
    rsp_en   = 1'b1;

    step(); step();
    to_neg();                                   // cycle 2: credit exhausted
    chk("c2_req",  {31'b0, ibus.req}, 32'h0);
    chk("c2_addr", ibus.addr,         32'h8);
    to_neg();                                   // cycle 3: first instruction
    chk("c3_iaddr", inst_addr_out,           32'h0);
    chk("c3_inst",  inst_out,                32'h0);
    chk("c3_valid", {31'b0, inst_valid_out}, 32'h1);
    to_neg();
    chk("c4_iaddr", inst_addr_out, 32'h4);
    chk("c4_inst",  inst_out,      32'h1);
    to_neg();                                   // FIFO ran dry for one cycle
    chk("c5_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("c5_inst",  inst_out,                NOP_V);
    chk("c5_iaddr", inst_addr_out,           32'h4);
    to_neg();
    chk("c6_iaddr", inst_addr_out, 32'h8);
    chk("c6_inst",  inst_out,      32'h2);

    // stall for 3 cycles mid-stream
    repeat (4) step();
    stall_in = 1'b1;
    step(); step();
    to_neg();
    chk("stall_req_off", {31'b0, ibus.req}, 32'h0);
    step();
    stall_in = 1'b0;
    repeat (6) step();

    // grant withheld
    gnt_en = 1'b0;
    repeat (5) step();
    to_neg();
    chk("nognt_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("nognt_inst",  inst_out,                NOP_V);
    step();
    gnt_en = 1'b1;
    repeat (5) step();

    // redirect with two requests outstanding
    rsp_en = 1'b0;
    repeat (4) step();
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h100;
    step();
    jump_flag_in = 1'b0;
    rsp_en       = 1'b1;
    wait_valid("jump_first", 20);
    chk("jump_iaddr", inst_addr_out, 32'h100);
    chk("jump_inst",  inst_out,      32'h40);
    repeat (4) step();

    // redirect in the same cycle as a response
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #3;
      if (ibus.rvalid) begin
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h200;
        break;
      end
    end
    step();
    jump_flag_in = 1'b0;
    wait_valid("rvjump_first", 20);
    chk("rvjump_iaddr", inst_addr_out, 32'h200);
    chk("rvjump_inst",  inst_out,      32'h80);
    repeat (5) step();

    // asynchronous reset mid-stream; stale responses must be ignored
    @(posedge clk_in);
    #3;
    reset_in = 1'b1;
    gnt_en   = 1'b0;
    #1;
    chk("arst_inst",  inst_out,                NOP_V);
    chk("arst_iaddr", inst_addr_out,           32'h0);
    chk("arst_valid", {31'b0, inst_valid_out}, 32'h0);
    chk("arst_req",   {31'b0, ibus.req},       32'h0);
    step();
    reset_in = 1'b0;
    repeat (3) step();
    gnt_en = 1'b1;
    wait_valid("restart_first", 20);
    chk("restart_iaddr", inst_addr_out, 32'h0);
    chk("restart_inst",  inst_out,      32'h0);
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
